// File: rtl/seg_scan_driver.sv
// seg_scan_driver: N-digit 7-segment scanner with PWM dimming, ghost guard and frame strobe; SEG_LZ_BLANK_EN adds leading-zero blanking.
// Latency: one clk from internal state to the registered pins; no backpressure (free-running scan).
module seg_scan_driver #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 1000,
  parameter int GUARD       = 4,
  parameter int BRIGHT_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  load,
  input  logic                  enable,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [SW-1:0]       SLOT_LAST = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0]       GUARD_C   = SW'(GUARD);
  localparam logic [IW-1:0]       IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ONE_HOT0  = N_DIGITS'(1);

  logic [SW-1:0]         slot_cnt;
  logic [IW-1:0]         idx;
  logic [BRIGHT_W-1:0]   pwm_cnt;
  logic [4*N_DIGITS-1:0] data_sh;
  logic [N_DIGITS-1:0]   dp_sh;
  logic [N_DIGITS-1:0]   en_sh;
  logic                  wrap_q;
  logic                  slot_last;
  logic                  idx_last;
  logic                  pwm_on;
  logic                  blank_cur;
  logic                  lit;
  logic [3:0]            nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

`ifdef SEG_LZ_BLANK_EN
  logic [N_DIGITS-1:0] lz_mask;
  logic [N_DIGITS-1:0] lz_next;
  logic                lz_run;

  // Mask is built from the word being loaded so it lands in the same edge as the shadow copy.
  always_comb begin
    lz_next = '0;
    lz_run  = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      lz_run     = lz_run && (data[4*k +: 4] == 4'h0) && !dp_in[k];
      lz_next[k] = lz_run;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lz_mask <= '0;
    end else if (load) begin
      lz_mask <= lz_next;
    end
  end

  assign blank_cur = lz_mask[idx];
`else
  assign blank_cur = 1'b0;
`endif

  assign slot_last = (slot_cnt == SLOT_LAST);
  assign idx_last  = (idx == IDX_LAST);
  assign pwm_on    = (&brightness) || (pwm_cnt < brightness);
  assign nib       = data_sh[{idx, 2'b00} +: 4];
  assign lit       = enable && en_sh[idx] && (slot_cnt >= GUARD_C) && pwm_on && !blank_cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt   <= '0;
      idx        <= '0;
      pwm_cnt    <= '0;
      data_sh    <= '0;
      dp_sh      <= '0;
      en_sh      <= '0;
      wrap_q     <= 1'b0;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      pwm_cnt  <= pwm_cnt + 1'b1;
      slot_cnt <= slot_last ? '0 : slot_cnt + 1'b1;
      if (slot_last) begin
        idx <= idx_last ? '0 : idx + 1'b1;
      end
      // Extra stage lines the strobe up with the pins showing digit 0 again.
      wrap_q     <= slot_last && idx_last;
      frame_done <= wrap_q;
      if (load) begin
        data_sh <= data;
        dp_sh   <= dp_in;
        en_sh   <= digit_en;
      end
      an  <= lit ? ~(ONE_HOT0 << idx) : '1;
      seg <= lit ? hex7(nib) : 7'h7F;
      dp  <= lit ? ~dp_sh[idx] : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: arithmetic reference model checked every cycle, plus literal scenario checks.
module tb_seg_scan_driver;

  localparam int ND  = 4;
  localparam int DIV = 8;
  localparam int GRD = 1;
  localparam int BW  = 2;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic          clk;
  logic          reset;
  logic [15:0]   data;
  logic [3:0]    dp_in;
  logic [3:0]    digit_en;
  logic          load;
  logic          enable;
  logic [BW-1:0] brightness;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_done;

  int total = 0;
  int bad   = 0;

  // Model state: edges since reset release and the word most recently loaded.
  int          cnt = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_en = '0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fd;

  seg_scan_driver #(.N_DIGITS(ND), .REFRESH_DIV(DIV), .GUARD(GRD), .BRIGHT_W(BW)) dut (
    .clk(clk), .reset(reset), .data(data), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .enable(enable), .brightness(brightness),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEG_LZ_BLANK_EN
  function automatic bit lz_blank(input logic [15:0] d, input logic [3:0] p, input int k);
    bit run = 1'b1;
    for (int j = ND - 1; j >= k; j--) run = run && (d[4*j +: 4] == 4'h0) && !p[j];
    return (k != 0) && run;
  endfunction
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic watch(input int n, output int lit, output int fds, output int hitb);
    lit = 0; fds = 0; hitb = 0;
    repeat (n) begin
      @(negedge clk);
      if (an !== 4'hF) lit++;
      if (frame_done === 1'b1) fds++;
      if (an === 4'hB) hitb++;
    end
  endtask

  // Per-cycle reference: pins after an edge reflect the model state before that edge.
  always @(posedge clk) begin
    int  slot, idx;
    bit  on, lzb;
    logic [3:0] one;
    one = 4'b0001;
    if (reset) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      cnt = 0; m_data = '0; m_dp = '0; m_en = '0;
    end else begin
      slot = cnt % DIV;
      idx  = (cnt / DIV) % ND;
      lzb  = 1'b0;
`ifdef SEG_LZ_BLANK_EN
      lzb  = lz_blank(m_data, m_dp, idx);
`endif
      on = enable && m_en[idx] && (slot >= GRD) && !lzb &&
           ((int'(brightness) == (1 << BW) - 1) || ((cnt % (1 << BW)) < int'(brightness)));
      e_an  = on ? ~(one << idx) : 4'hF;
      e_seg = on ? HEX[m_data[4*idx +: 4]] : 7'h7F;
      e_dp  = on ? ~m_dp[idx] : 1'b1;
      e_fd  = (cnt > 0) && (cnt % (DIV * ND) == 0);
      if (load) begin
        m_data = data; m_dp = dp_in; m_en = digit_en;
      end
      cnt++;
    end
    #1;
    total++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_done !== e_fd) begin
      bad++;
      $display("FAIL model t=%0t an=%h/%h seg=%h/%h dp=%b/%b fd=%b/%b (got/want)",
               $time, an, e_an, seg, e_seg, dp, e_dp, frame_done, e_fd);
    end
  end

  initial begin
    int lit, fds, hitb, found, stray;
    reset = 1'b1; load = 1'b0; data = '0; dp_in = '0; digit_en = '0;
    enable = 1'b0; brightness = '0;
    step(3);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fd", frame_done, 1'b0);

    reset = 1'b0; load = 1'b1; data = 16'h3A0F; dp_in = 4'b0010; digit_en = 4'b1111;
    enable = 1'b1; brightness = 2'd3;
    step(1);
    load = 1'b0;
    chk("guard_d0", an, 4'hF);
    step(1);
    chk("d0_an", an, 4'hE);
    chk("d0_seg", seg, 7'h0E);
    chk("d0_dp", dp, 1'b1);
    step(8);
    chk("d1_an", an, 4'hD);
    chk("d1_seg", seg, 7'h40);
    chk("d1_dp", dp, 1'b0);
    step(16);
    chk("d3_an", an, 4'h7);
    chk("d3_seg", seg, 7'h30);
    step(7);
    chk("fd_pulse", frame_done, 1'b1);
    step(1);
    chk("fd_single", frame_done, 1'b0);

    step(5);
    reset = 1'b1;
    step(1);
    chk("midrst_an", an, 4'hF);
    chk("midrst_seg", seg, 7'h7F);
    step(2);
    reset = 1'b0; load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    chk("restart_an", an, 4'hE);
    chk("restart_seg", seg, 7'h0E);

    digit_en = 4'b1011; load = 1'b1;
    step(1);
    load = 1'b0;
    watch(64, lit, fds, hitb);
    chk("mask_no_b", hitb, 0);
    chk("mask_lit", lit, 42);

    digit_en = 4'b1111; load = 1'b1;
    step(1);
    load = 1'b0; brightness = 2'd1;
    watch(32, lit, fds, hitb);
    chk("bright1_lit", lit, 4);
    brightness = 2'd2;
    watch(32, lit, fds, hitb);
    chk("bright2_lit", lit, 12);
    brightness = 2'd0;
    watch(32, lit, fds, hitb);
    chk("bright0_lit", lit, 0);
    brightness = 2'd3; enable = 1'b0;
    watch(32, lit, fds, hitb);
    chk("disable_lit", lit, 0);
    chk("disable_fd", fds, 1);
    enable = 1'b1;

    data = 16'h1234;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (an === 4'hE) found = 1;
    end
    chk("unloaded_wait", found, 1);
    chk("unloaded_seg", seg, 7'h0E);

    found = 0;
    for (int i = 0; i < 16 && found == 0; i++) begin
      if (cnt % DIV == DIV - 1) found = 1;
      else @(negedge clk);
    end
    chk("wrap_wait", found, 1);
    data = 16'h7777; load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    chk("wrapload_guard", an, 4'hF);
    step(1);
    chk("wrapload_seg", seg, 7'h78);

`ifdef SEG_LZ_BLANK_EN
    data = 16'h0005; dp_in = 4'b0000; load = 1'b1;
    step(1);
    load = 1'b0;
    stray = 0;
    repeat (32) begin
      @(negedge clk);
      if (an !== 4'hF && an !== 4'hE) stray++;
    end
    chk("lz_only_d0", stray, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 9) == 0);
      if (load) begin
        data     = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
        dp_in    = 4'($urandom);
        digit_en = 4'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        data = 16'($urandom);
      end
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) brightness = BW'($urandom_range(0, 3));
    end
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
